audio_mix_dsm: RTL and testbench
================================

AUDIO_MIX_DSM -- requirements
Module: audio_mix_dsm

Interface
REQ-001 SHALL have parameter WIDTH, default 12, sample width in bits (signed two's complement), min 4.
REQ-002 SHALL have parameter CHANNELS, default 4, number of mixed voices, min 1, max 16.
REQ-003 SHALL have parameter VOL_W, default 4, per-channel volume width in bits (unsigned).
REQ-004 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  frame offered.
REQ-007 SHALL have port in_ready  output  1  frame can be accepted.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  signed samples; channel k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port in_vol  input  CHANNELS*VOL_W  per-channel volume, sampled with the frame.
REQ-010 SHALL have port mute  input  1  forces modulator level to midscale.
REQ-011 SHALL have port level  output  WIDTH  current unsigned offset-binary level (debug/observe).
REQ-012 SHALL have port pwm  output  1  1-bit density-modulated audio output.

Function
REQ-013 Frame handshake SHALL complete on a rising edge with in_valid=1 and in_ready=1; in_data and in_vol are captured into holding registers on that edge.
REQ-014 Mixer FSM SHALL have states IDLE, ACCUM, LATCH; IDLE->ACCUM on handshake; ACCUM runs exactly CHANNELS cycles (channel counter 0..CHANNELS-1) then ->LATCH; LATCH->IDLE after one cycle.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid in other states is ignored and no data captured.
REQ-016 In ACCUM, each cycle SHALL add (sample_k * vol_k) >>> VOL_W (arithmetic shift, full-precision product) into a signed sum of width WIDTH+clog2(CHANNELS)+1 cleared on handshake.
REQ-017 In LATCH, sum SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], convert to offset binary (invert MSB) and load level.
REQ-018 level SHALL update exactly CHANNELS+1 cycles after the handshake edge; in_ready returns high the cycle after.
REQ-019 While mute=1, the modulator input SHALL be 2^(WIDTH-1) regardless of level; level register still updates.
REQ-020 First-order modulator (default): accumulator WIDTH+1 bits, each cycle acc <= {0, acc[WIDTH-1:0]} + modulator input; pwm = acc[WIDTH].
REQ-021 Over 2^WIDTH cycles of constant input L, pwm high-count SHALL equal L exactly (first-order).
REQ-022 pwm SHALL be driven from a register only (glitch-free).

Reset
REQ-023 On reset: FSM=IDLE, in_ready=1, sum=0, channel counter=0, level=2^(WIDTH-1), modulator state=0, pwm=0.
REQ-024 Reset during ACCUM or LATCH SHALL abort the frame with no level update.

Configuration
REQ-025 Macro AUDIO_MIX_DSM_ORDER2_EN defined: modulator is second-order (two cascaded signed integrators, width WIDTH+3, feedback +/-2^(WIDTH-1) from pwm into both, pwm = integrator2 >= 0); undefined: first-order per REQ-020.
REQ-026 Both variants SHALL keep identical ports, handshake timing and reset values; REQ-021 exact-count rule applies to first-order only; second-order average density within +/-2 counts per 2^WIDTH cycles.

Structure
REQ-027 Shared package audio_pkg SHALL hold the FSM state enum, midscale constant function and the saturate helper.
REQ-028 Modulator SHALL be a sub-module audio_dsm_core (input level, mute-resolved; output pwm); mixer/FSM stays in audio_mix_dsm.

Verification
REQ-029 Reset, no frames, WIDTH=12 -> level=0x800, pwm high 2048 of 4096 cycles.
REQ-030 One frame, all channels 0x7FF, vol 15, CHANNELS=4 -> sum saturates, level=0xFFF on cycle 5 after handshake, pwm high 4095/4096.
REQ-031 One frame, all channels 0x800 (-2048), vol 15 -> level=0x000, pwm high 0/4096.
REQ-032 Channel0=0x400, vol0=8, others vol 0 -> contribution 0x200, level=0xA00, in_ready low cycles 1..5 after handshake.
REQ-033 in_valid held high continuously -> frames accepted every CHANNELS+2 cycles, none accepted while in_ready=0.
REQ-034 Reset asserted in ACCUM cycle 2 -> level stays 0x800, in_ready=1 next cycle; mute=1 with level=0xFFF -> pwm high 2048/4096.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio mixer / delta-sigma modulator slice.
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      LATCH = 2'd2
   } mix_state_t;

   // 2^(width-1): offset-binary zero point and signed full-scale magnitude
   function automatic logic [63:0] midscale(input int unsigned width);
      return 64'd1 << (width - 1);
   endfunction

   // Clamp a signed value into the signed range of a width-bit word
   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                   input int unsigned       width);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = $signed(midscale(width)) - 64'sd1;
      lo = -$signed(midscale(width));
      if (value > hi)
         return hi;
      else if (value < lo)
         return lo;
      else
         return value;
   endfunction

endpackage

// File: rtl/audio_dsm_core.sv
// 1-bit delta-sigma modulator driven by an offset-binary level.
// AUDIO_MIX_DSM_ORDER2_EN selects the second-order loop; default is first-order.
module audio_dsm_core
   import audio_pkg::*;
#(
   parameter int unsigned WIDTH = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] level,
   output logic             pwm
);

`ifdef AUDIO_MIX_DSM_ORDER2_EN
   localparam int unsigned IW = WIDTH + 3;
   localparam logic signed [IW-1:0] HALF = $signed(IW'(midscale(WIDTH)));

   logic signed [IW-1:0] int1, int2;
   logic signed [IW-1:0] x, fb, int1_n, int2_n;

   // Two cascaded integrators, both fed back from the registered bit
   always_comb begin
      x      = $signed(IW'(level)) - HALF;
      fb     = pwm ? HALF : -HALF;
      int1_n = int1 + x - fb;
      int2_n = int2 + int1_n - fb;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         int1 <= '0;
         int2 <= '0;
         pwm  <= 1'b0;
      end else begin
         int1 <= int1_n;
         int2 <= int2_n;
         pwm  <= ~int2_n[IW-1];
      end
   end
`else
   logic [WIDTH:0] acc;

   // Carry out of the phase accumulator is the output bit
   always_ff @(posedge clk) begin
      if (reset)
         acc <= '0;
      else
         acc <= {1'b0, acc[WIDTH-1:0]} + {1'b0, level};
   end

   assign pwm = acc[WIDTH];
`endif

endmodule

// File: rtl/audio_mix_dsm.sv
// Multi-channel volume mixer feeding a 1-bit delta-sigma output.
// Build with AUDIO_MIX_DSM_ORDER2_EN for the second-order modulator.
module audio_mix_dsm
   import audio_pkg::*;
#(
   parameter int unsigned WIDTH    = 12,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned VOL_W    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS*VOL_W-1:0] in_vol,
   input  logic                      mute,
   output logic [WIDTH-1:0]          level,
   output logic                      pwm
);

   localparam int unsigned SUM_W  = WIDTH + $clog2(CHANNELS) + 1;
   localparam int unsigned PROD_W = WIDTH + VOL_W + 1;
   localparam int unsigned CNT_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [WIDTH-1:0] MID     = WIDTH'(midscale(WIDTH));
   localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

   mix_state_t state, state_n;

   logic [CNT_W-1:0]          ch_cnt;
   logic [CHANNELS*WIDTH-1:0] data_q;
   logic [CHANNELS*VOL_W-1:0] vol_q;
   logic signed [SUM_W-1:0]   sum;
   logic signed [SUM_W-1:0]   contrib;
   logic signed [WIDTH-1:0]   sample;
   logic [VOL_W-1:0]          vol;
   logic signed [PROD_W-1:0]  prod;
   logic signed [WIDTH-1:0]   sat;
   logic [WIDTH-1:0]          level_n;
   logic [WIDTH-1:0]          dsm_in;
   logic                      handshake;

   assign handshake = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (handshake) state_n = ACCUM;
         ACCUM:   if (ch_cnt == LAST_CH) state_n = LATCH;
         LATCH:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Per-channel weighted contribution and final saturation to offset binary
   always_comb begin
      sample  = $signed(data_q[ch_cnt*WIDTH +: WIDTH]);
      vol     = vol_q[ch_cnt*VOL_W +: VOL_W];
      prod    = $signed(PROD_W'(sample)) * $signed(PROD_W'({1'b0, vol}));
      contrib = SUM_W'(prod >>> VOL_W);
      sat     = WIDTH'(saturate(64'(sum), WIDTH));
      level_n = WIDTH'(sat) ^ MID;
      dsm_in  = mute ? MID : level;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready <= 1'b1;
         ch_cnt   <= '0;
         sum      <= '0;
         data_q   <= '0;
         vol_q    <= '0;
         level    <= MID;
      end else begin
         in_ready <= (state_n == IDLE);
         if (handshake) begin
            data_q <= in_data;
            vol_q  <= in_vol;
            sum    <= '0;
            ch_cnt <= '0;
         end
         if (state == ACCUM) begin
            sum    <= sum + contrib;
            ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CNT_W'(1);
         end
         if (state == LATCH)
            level <= level_n;
      end
   end

   audio_dsm_core #(
      .WIDTH (WIDTH)
   ) u_dsm (
      .clk   (clk),
      .reset (reset),
      .level (dsm_in),
      .pwm   (pwm)
   );

endmodule

// File: tb/tb_audio_mix_dsm.sv
// Scoreboard bench for audio_mix_dsm at default parameters (first-order build).
module tb_audio_mix_dsm;

   localparam int unsigned W  = 12;
   localparam int unsigned C  = 4;
   localparam int unsigned V  = 4;
   localparam int unsigned DW = W * C;
   localparam int unsigned VW = V * C;
   localparam int unsigned N  = 1 << W;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          in_valid = 1'b0;
   logic          mute     = 1'b0;
   logic [DW-1:0] in_data  = '0;
   logic [VW-1:0] in_vol   = '0;
   logic          in_ready;
   logic [W-1:0]  level;
   logic          pwm;

   always #5 clk = ~clk;

   audio_mix_dsm #(
      .WIDTH    (W),
      .CHANNELS (C),
      .VOL_W    (V)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_vol   (in_vol),
      .mute     (mute),
      .level    (level),
      .pwm      (pwm)
   );

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic ready_prev;
   logic [W-1:0] exp_q[$];
   int hs_q[$];
   int hs_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference mix: weighted sum, clamp, offset-binary
   function automatic logic [W-1:0] model(input logic [DW-1:0] d, input logic [VW-1:0] v);
      int acc;
      int s;
      int g;
      acc = 0;
      for (int k = 0; k < int'(C); k++) begin
         s = int'($signed(d[k*W +: W]));
         g = int'(v[k*V +: V]);
         acc += (s * g) >>> V;
      end
      if (acc > (1 << (W - 1)) - 1) acc = (1 << (W - 1)) - 1;
      if (acc < -(1 << (W - 1)))    acc = -(1 << (W - 1));
      return W'(acc) ^ W'(1 << (W - 1));
   endfunction

   // Push on accepted frames, compare when the DUT reports frame completion
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            exp_q.delete();
            hs_q.delete();
         end else if (in_valid && in_ready) begin
            exp_q.push_back(model(in_data, in_vol));
            hs_q.push_back(cyc);
            hs_log.push_back(cyc);
         end
         cyc++;
         @(negedge clk);
         if (in_ready && !ready_prev && exp_q.size() > 0) begin
            check("level", 32'(level), 32'(exp_q.pop_front()));
            check("latency", 32'(cyc - 1 - hs_q.pop_front()), 32'(C + 1));
         end
         ready_prev = in_ready;
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (in_ready) return;
         @(negedge clk);
      end
      check("idle_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic [VW-1:0] v);
      wait_idle();
      in_valid = 1'b1;
      in_data  = d;
      in_vol   = v;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic count_pwm(output int c);
      c = 0;
      repeat (N) begin
         @(negedge clk);
         c += int'(pwm);
      end
   endtask

   initial begin
      int c;
      int base;
      logic [DW-1:0] d;
      logic [VW-1:0] v;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_level", 32'(level), 32'h800);
      check("rst_pwm", 32'(pwm), 32'd0);
      count_pwm(c);
      check("pwm_mid", 32'(c), 32'd2048);

      // reset while accumulating aborts the frame
      send_frame({C{12'h7FF}}, {C{4'hF}});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_ready", 32'(in_ready), 32'd1);
      check("abort_level", 32'(level), 32'h800);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("abort_hold", 32'(level), 32'h800);

      // positive full scale saturates, then mute forces midscale
      send_frame({C{12'h7FF}}, {C{4'hF}});
      wait_idle();
      check("level_fff", 32'(level), 32'hFFF);
      @(negedge clk);
      count_pwm(c);
      check("pwm_full", 32'(c), 32'd4095);
      mute = 1'b1;
      count_pwm(c);
      check("pwm_mute", 32'(c), 32'd2048);
      check("mute_level", 32'(level), 32'hFFF);
      mute = 1'b0;

      // negative full scale
      send_frame({C{12'h800}}, {C{4'hF}});
      wait_idle();
      @(negedge clk);
      count_pwm(c);
      check("pwm_zero", 32'(c), 32'd0);

      // single weighted channel and ready timing
      d = DW'({$urandom(), $urandom()});
      d[W-1:0] = 12'h400;
      v = '0;
      v[V-1:0] = 4'd8;
      send_frame(d, v);
      check("rdy_low", 32'(in_ready), 32'd0);
      for (int i = 2; i <= 5; i++) begin
         @(negedge clk);
         check("rdy_low", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      check("rdy_back", 32'(in_ready), 32'd1);
      check("level_a00", 32'(level), 32'hA00);
      @(negedge clk);
      count_pwm(c);
      check("pwm_a00", 32'(c), 32'hA00);

      // level keeps updating while muted
      mute = 1'b1;
      send_frame(DW'({$urandom(), $urandom()}), VW'($urandom()));
      wait_idle();
      mute = 1'b0;

      // in_valid held high with data changing every cycle
      wait_idle();
      base = hs_log.size();
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = DW'({$urandom(), $urandom()});
         in_vol  = VW'($urandom());
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("burst_count", 32'(hs_log.size() - base), 32'd4);
      for (int i = base + 1; i < hs_log.size(); i++)
         check("burst_gap", 32'(hs_log[i] - hs_log[i-1]), 32'(C + 2));
      wait_idle();

      // random frames through the scoreboard
      repeat (6) send_frame(DW'({$urandom(), $urandom()}), VW'($urandom()));
      wait_idle();
      repeat (2) @(negedge clk);
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
